// File: rtl/i2c_codec_responder_pkg.sv
// codec_pkg: shared constants for the WM8731 control-port responder.
//   - WM8731 register addresses (R0..R9, R15 reset register)
//   - power-on default values of the shadow register file
//   - responder FSM state encodings
package codec_pkg;

    localparam logic [6:0] REG_R0    = 7'd0;
    localparam logic [6:0] REG_R1    = 7'd1;
    localparam logic [6:0] REG_R2    = 7'd2;
    localparam logic [6:0] REG_R3    = 7'd3;
    localparam logic [6:0] REG_R4    = 7'd4;
    localparam logic [6:0] REG_R5    = 7'd5;
    localparam logic [6:0] REG_R6    = 7'd6;
    localparam logic [6:0] REG_R7    = 7'd7;
    localparam logic [6:0] REG_R8    = 7'd8;
    localparam logic [6:0] REG_R9    = 7'd9;
    localparam logic [6:0] REG_RESET = 7'd15;

    // Registers 0..NUM_REGS-1 are backed by shadow storage.
    localparam logic [6:0] NUM_REGS  = 7'd10;

    // Packed so that REG_DEFAULTS[n] is the default of Rn.
    localparam logic [9:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
        9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
    };

    // Responder FSM encodings.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEV      = 3'd1;
    localparam logic [2:0] ST_ACK_DEV  = 3'd2;
    localparam logic [2:0] ST_REG      = 3'd3;
    localparam logic [2:0] ST_ACK_REG  = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_ACK_DATA = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

endpackage

// File: rtl/i2c_codec_responder_if.sv
// I2C bus as seen at the codec pins.
//   scl    : clock from the initiator
//   sda    : resolved data line (wired-AND of all drivers)
//   sda_oe : target open-drain enable, 1 = pull SDA low
// master modport is the initiator side, slave modport the codec side.
interface i2c_codec_responder_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport master (output scl, output sda, input  sda_oe);
    modport slave  (input  scl, input  sda, output sda_oe);
endinterface

// File: rtl/i2c_codec_responder_cond_detect.sv
// i2c_cond_detect: brings async SCL/SDA into the i_clk domain and derives
// bus events from the synchronized values.
//   i_clk, i_rst_n : system clock, async active-low reset
//   scl_in, sda_in : raw bus lines
//   sda            : synchronized SDA (for data sampling)
//   scl_rise/fall  : one-cycle SCL edge strobes
//   start/stop     : one-cycle START / STOP strobes
module i2c_cond_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_q;
    assign scl_fall = ~scl_s &  scl_q;
    // SDA may only move while SCL is low; a move with SCL held high is a
    // bus condition, never data.
    assign start    = scl_s & scl_q &  sda_q & ~sda;
    assign stop     = scl_s & scl_q & ~sda_q &  sda;

endmodule

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: I2C write-only target modelling the WM8731 control
// port. Accepts 3-byte writes {dev, addr[6:0]+data[8], data[7:0]}, ACKs
// them, and keeps a shadow copy of R0..R9.
//   i_clk, i_rst_n : system clock (>=16x SCL), async active-low reset
//   bus            : I2C pins (slave modport)
//   o_wr_valid     : one-cycle pulse per committed write
//   o_wr_addr/data : last committed address/data, held until next commit
//   i_rd_addr      : shadow register readback select
//   o_rd_data      : shadow register value, 0 for addr > 9
//   o_busy         : between START and STOP
//   o_bad_reg      : sticky, write to an address outside {0-9,15}
//   o_wr_count     : committed-write counter (wraps)
module i2c_codec_responder
    import codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    i2c_codec_responder_if.slave  bus,
    output logic                  o_wr_valid,
    output logic [6:0]            o_wr_addr,
    output logic [8:0]            o_wr_data,
    input  logic [3:0]            i_rd_addr,
    output logic [8:0]            o_rd_data,
    output logic                  o_busy,
    output logic                  o_bad_reg,
    output logic [7:0]            o_wr_count
);

    logic            sda;
    logic            scl_rise;
    logic            scl_fall;
    logic            start;
    logic            stop;

    logic [2:0]      state;
    logic [2:0]      bit_cnt;
    logic            byte_full;
    logic [7:0]      shreg;
    logic [6:0]      reg_addr;
    logic            reg_b8;
    logic            sda_oe;
    logic [9:0][8:0] regs;

    i2c_cond_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cond (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .scl_in   (bus.scl),
        .sda_in   (bus.sda),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            byte_full  <= 1'b0;
            shreg      <= 8'd0;
            reg_addr   <= 7'd0;
            reg_b8     <= 1'b0;
            sda_oe     <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= 7'd0;
            o_wr_data  <= 9'd0;
            o_wr_count <= 8'd0;
            o_bad_reg  <= 1'b0;
            regs       <= REG_DEFAULTS;
        end else begin
            o_wr_valid <= 1'b0;
            // Bus conditions override whatever byte is in flight; an
            // uncommitted write is simply dropped.
            if (stop) begin
                state     <= ST_IDLE;
                o_busy    <= 1'b0;
                sda_oe    <= 1'b0;
                byte_full <= 1'b0;
            end else if (start) begin
                state     <= ST_DEV;
                o_busy    <= 1'b1;
                sda_oe    <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
            end else begin
                case (state)
                    ST_DEV, ST_REG, ST_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                byte_full <= 1'b1;
                        end else if (scl_fall && byte_full) begin
                            // Eighth clock has ended: drive (or withhold)
                            // the ACK for the ninth clock.
                            byte_full <= 1'b0;
                            if (state == ST_DEV) begin
                                if (shreg == {DEV_ADDR, 1'b0}) begin
                                    sda_oe <= 1'b1;
                                    state  <= ST_ACK_DEV;
                                end else begin
                                    state  <= ST_IGNORE;
                                end
                            end else if (state == ST_REG) begin
                                reg_addr <= shreg[7:1];
                                reg_b8   <= shreg[0];
                                sda_oe   <= 1'b1;
                                state    <= ST_ACK_REG;
                            end else begin
                                sda_oe   <= 1'b1;
                                state    <= ST_ACK_DATA;
                            end
                        end
                    end

                    ST_ACK_DEV, ST_ACK_REG, ST_ACK_DATA: begin
                        if (scl_rise && sda) begin
                            // Line not low while we pull it: something else
                            // owns the bus, back off.
                            sda_oe <= 1'b0;
                            state  <= ST_IGNORE;
                        end else if (scl_fall) begin
                            sda_oe <= 1'b0;
                            if (state == ST_ACK_DEV) begin
                                state <= ST_REG;
                            end else if (state == ST_ACK_REG) begin
                                state <= ST_DATA;
                            end else begin
                                // Data byte still sits in shreg: the ACK
                                // clock does not shift.
                                state      <= ST_IGNORE;
                                o_wr_valid <= 1'b1;
                                o_wr_addr  <= reg_addr;
                                o_wr_data  <= {reg_b8, shreg};
                                o_wr_count <= o_wr_count + 8'd1;
                                if (reg_addr < NUM_REGS)
                                    regs[reg_addr[3:0]] <= {reg_b8, shreg};
                                else if (reg_addr == REG_RESET)
                                    regs <= REG_DEFAULTS;
                                else
                                    o_bad_reg <= 1'b1;
                            end
                        end
                    end

                    default: ;  // IDLE / IGNORE: wait for START or STOP
                endcase
            end
        end
    end

    assign bus.sda_oe = sda_oe;
    assign o_rd_data  = ({3'd0, i_rd_addr} < NUM_REGS) ? regs[i_rd_addr] : 9'd0;

endmodule

// File: tb/tb_i2c_codec_responder.sv
module tb_i2c_codec_responder;
    import codec_pkg::*;

    localparam int Q = 5;  // quarter SCL period in i_clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sda_m = 1'b1;
    logic       wr_valid, busy, bad_reg;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] wr_count;
    int         n_checks = 0;
    int         n_pass = 0;
    int         pulses = 0;
    int         p0;
    logic [2:0] acks;
    logic       ack;

    always #5 clk = ~clk;

    i2c_codec_responder_if bus ();
    assign bus.sda = sda_m & ~bus.sda_oe;  // open-drain wired-AND

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_busy     (busy),
        .o_bad_reg  (bad_reg),
        .o_wr_count (wr_count)
    );

    always @(posedge clk) if (rst_n && wr_valid) pulses <= pulses + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_rd(input string tag, input logic [3:0] a, input logic [8:0] exp);
        rd_addr = a;
        #1;
        check(tag, {23'd0, rd_data}, {23'd0, exp});
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        bus.scl = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        bus.scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        bus.scl = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; tick(Q);
            bus.scl = 1'b1; tick(2 * Q);
            bus.scl = 1'b0; tick(Q);
        end
    endtask

    task automatic ack_clk(output logic a);
        sda_m = 1'b1; tick(Q);
        bus.scl = 1'b1; tick(Q);
        a = (bus.sda === 1'b0);
        tick(Q);
        bus.scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        send_bits(b, 8);
        ack_clk(a);
    endtask

    task automatic xfer(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, output logic [2:0] a);
        i2c_start();
        write_byte(b0, a[2]);
        write_byte(b1, a[1]);
        write_byte(b2, a[0]);
    endtask

    // Initializer-style replay table: {addr, data}
    logic [6:0] rp_addr [10] = '{7'd15, 7'd6, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd7, 7'd9};
    logic [8:0] rp_data [10] = '{9'h000, 9'h010, 9'h017, 9'h017, 9'h079,
                                 9'h079, 9'h012, 9'h000, 9'h00A, 9'h001};

    initial begin
        bus.scl = 1'b1;
        tick(3);
        // reset state
        check("rst_oe", {31'd0, bus.sda_oe}, 0);
        check("rst_valid", {31'd0, wr_valid}, 0);
        check("rst_addr", {25'd0, wr_addr}, 0);
        check("rst_data", {23'd0, wr_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_bad", {31'd0, bad_reg}, 0);
        check("rst_count", {24'd0, wr_count}, 0);
        check_rd("rst_r0", 4'd0, 9'h097);
        check_rd("rst_r6", 4'd6, 9'h09F);
        rst_n = 1'b1;
        tick(5);

        // R4 = 0x015
        p0 = pulses;
        xfer(8'h34, 8'h08, 8'h15, acks);
        check("t1_acks", {29'd0, acks}, 3'b111);
        check("t1_busy", {31'd0, busy}, 1);
        i2c_stop();
        check("t1_idle", {31'd0, busy}, 0);
        check("t1_pulses", pulses - p0, 1);
        check("t1_addr", {25'd0, wr_addr}, 7'h04);
        check("t1_data", {23'd0, wr_data}, 9'h015);
        check_rd("t1_r4", 4'd4, 9'h015);
        check("t1_count", {24'd0, wr_count}, 1);

        // R6 = 0x1FF, bit 8 from the register byte
        xfer(8'h34, 8'h0D, 8'hFF, acks);
        i2c_stop();
        check("t2_acks", {29'd0, acks}, 3'b111);
        check("t2_data", {23'd0, wr_data}, 9'h1FF);
        check_rd("t2_r6", 4'd6, 9'h1FF);
        check("t2_count", {24'd0, wr_count}, 2);

        // wrong device address
        p0 = pulses;
        xfer(8'h36, 8'h08, 8'h22, acks);
        check("t3_acks", {29'd0, acks}, 3'b000);
        i2c_stop();
        check("t3_idle", {31'd0, busy}, 0);
        check("t3_pulses", pulses - p0, 0);
        check_rd("t3_r4", 4'd4, 9'h015);
        check("t3_count", {24'd0, wr_count}, 2);

        // truncated by STOP, then by repeated START mid data byte
        p0 = pulses;
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h08, ack);
        i2c_stop();
        check("t4_stop_abort", pulses - p0, 0);
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h08, ack);
        send_bits(8'h55, 4);
        i2c_start();
        check("t4_rs_abort", pulses - p0, 0);
        check("t4_rs_oe", {31'd0, bus.sda_oe}, 0);
        write_byte(8'h34, acks[2]);
        write_byte(8'h02, acks[1]);
        write_byte(8'h55, acks[0]);
        i2c_stop();
        check("t4_acks", {29'd0, acks}, 3'b111);
        check("t4_pulses", pulses - p0, 1);
        check_rd("t4_r1", 4'd1, 9'h055);
        check_rd("t4_r4", 4'd4, 9'h015);
        check("t4_count", {24'd0, wr_count}, 3);

        // R15 reset register
        xfer(8'h34, 8'h1E, 8'h00, acks);
        i2c_stop();
        check_rd("t5_r4", 4'd4, 9'h00A);
        check_rd("t5_r6", 4'd6, 9'h09F);
        check_rd("t5_r1", 4'd1, 9'h097);
        check("t5_addr", {25'd0, wr_addr}, 7'h0F);
        check("t5_bad", {31'd0, bad_reg}, 0);
        check("t5_count", {24'd0, wr_count}, 4);

        // unmapped address 12
        xfer(8'h34, 8'h18, 8'h01, acks);
        i2c_stop();
        check("t6_acks", {29'd0, acks}, 3'b111);
        check("t6_bad", {31'd0, bad_reg}, 1);
        check("t6_addr", {25'd0, wr_addr}, 7'h0C);
        check("t6_data", {23'd0, wr_data}, 9'h001);
        check_rd("t6_r4", 4'd4, 9'h00A);
        check_rd("t6_rd12", 4'd12, 9'h000);
        check("t6_count", {24'd0, wr_count}, 5);

        // fourth byte is not acknowledged
        p0 = pulses;
        xfer(8'h34, 8'h0A, 8'h07, acks);
        write_byte(8'hAA, ack);
        i2c_stop();
        check("t7_ack4", {31'd0, ack}, 0);
        check("t7_pulses", pulses - p0, 1);
        check_rd("t7_r5", 4'd5, 9'h007);

        // async reset while ACK is driven
        i2c_start();
        send_bits(8'h34, 8);
        sda_m = 1'b1;
        tick(Q);
        check("t8_oe_on", {31'd0, bus.sda_oe}, 1);
        rst_n = 1'b0;
        #1;
        check("t8_oe_off", {31'd0, bus.sda_oe}, 0);
        check("t8_busy", {31'd0, busy}, 0);
        check("t8_count", {24'd0, wr_count}, 0);
        check("t8_bad", {31'd0, bad_reg}, 0);
        bus.scl = 1'b1;
        sda_m = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check_rd("t8_r5", 4'd5, 9'h008);

        // initializer replay
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            xfer(8'h34, {rp_addr[i], rp_data[i][8]}, rp_data[i][7:0], acks);
            i2c_stop();
            check("t9_acks", {29'd0, acks}, 3'b111);
            if (rp_addr[i] < 7'd10)
                check_rd("t9_rd", rp_addr[i][3:0], rp_data[i]);
            else
                check_rd("t9_r0", 4'd0, 9'h097);
        end
        check("t9_pulses", pulses - p0, 10);
        check("t9_count", {24'd0, wr_count}, 10);
        check_rd("t9_r8", 4'd8, 9'h000);
        check("t9_bad", {31'd0, bad_reg}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
